// File: rtl/ccc_lock_rst_pkg.sv
// Shared types and default constants for the CCC lock-qualified reset controller.
package ccc_lock_rst_pkg;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_STABLE = 2'd1,
    S_HOLD   = 2'd2,
    S_RUN    = 2'd3
  } lock_state_t;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_RST_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_CNT_W              = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES     = 65536;

  // Bits needed to hold a count running 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous CCC LOCK into the GL0 domain.
module ccc_lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/ccc_lock_reset_ctrl.sv
// Qualifies CCC LOCK and generates the fabric reset/READY with sticky lock-loss diagnostics.
// Optional lock-acquire timeout is built only when LOCK_TIMEOUT_EN is defined.
module ccc_lock_reset_ctrl
  import ccc_lock_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
  parameter int unsigned CNT_W              = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
  input  logic             GL0,
  input  logic             RESET_N,
  input  logic             LOCK,
  input  logic             CLR_STATUS,
  output logic             SYS_RESET_N,
  output logic             READY,
  output logic             LOCK_LOST,
  output logic [CNT_W-1:0] LOSS_COUNT,
  output logic             LOCK_TIMEOUT
);

  localparam int unsigned QMAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                 LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned QW   = cnt_bits(QMAX);
  localparam logic [QW-1:0] STABLE_LAST = QW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [QW-1:0] HOLD_LAST   = QW'(RST_HOLD_CYCLES - 1);

  logic        lock_s;
  lock_state_t state_reg, state_next;
  logic [QW-1:0] cnt_reg, cnt_next;
  logic        loss_event;

  ccc_lock_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk   (GL0),
    .rst_n (RESET_N),
    .d     (LOCK),
    .q     (lock_s)
  );

  // One counter serves both qualification phases; any lock_s drop restarts from S_WAIT.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_WAIT: begin
        cnt_next = '0;
        if (lock_s) state_next = S_STABLE;
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_RUN: begin
        cnt_next = '0;
        if (!lock_s) state_next = S_WAIT;
      end
      default: begin
        state_next = S_WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  assign loss_event = (state_reg == S_RUN) && !lock_s;

  always_ff @(posedge GL0) begin
    if (!RESET_N) begin
      state_reg   <= S_WAIT;
      cnt_reg     <= '0;
      SYS_RESET_N <= 1'b0;
      READY       <= 1'b0;
      LOCK_LOST   <= 1'b0;
      LOSS_COUNT  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      SYS_RESET_N <= (state_next == S_RUN);
      READY       <= (state_next == S_RUN);
      // A loss in the same cycle as a clear leaves a fresh count of one.
      if (loss_event) begin
        LOCK_LOST <= 1'b1;
        if (CLR_STATUS) begin
          LOSS_COUNT <= CNT_W'(1);
        end else if (LOSS_COUNT != '1) begin
          LOSS_COUNT <= LOSS_COUNT + 1'b1;
        end
      end else if (CLR_STATUS) begin
        LOCK_LOST  <= 1'b0;
        LOSS_COUNT <= '0;
      end
    end
  end

`ifdef LOCK_TIMEOUT_EN
  localparam int unsigned TW = cnt_bits(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt_reg;
  logic          timeout_reg;

  always_ff @(posedge GL0) begin
    if (!RESET_N) begin
      tcnt_reg    <= '0;
      timeout_reg <= 1'b0;
    end else if (CLR_STATUS) begin
      tcnt_reg    <= '0;
      timeout_reg <= 1'b0;
    end else if ((state_reg == S_RUN) || (state_next == S_RUN)) begin
      tcnt_reg <= '0;
    end else if (tcnt_reg == TO_LAST) begin
      timeout_reg <= 1'b1;
    end else begin
      tcnt_reg <= tcnt_reg + 1'b1;
    end
  end

  assign LOCK_TIMEOUT = timeout_reg;
`else
  assign LOCK_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_ccc_lock_reset_ctrl.sv
// Directed self-checking bench for ccc_lock_reset_ctrl (8-cycle stability, 4-cycle hold, 2-bit loss count).
module tb_ccc_lock_reset_ctrl;

  logic       GL0 = 1'b0;
  logic       RESET_N;
  logic       LOCK;
  logic       CLR_STATUS;
  logic       SYS_RESET_N;
  logic       READY;
  logic       LOCK_LOST;
  logic [1:0] LOSS_COUNT;
  logic       LOCK_TIMEOUT;

  int checks = 0;
  int errors = 0;

  always #5 GL0 = ~GL0;

  ccc_lock_reset_ctrl #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .RST_HOLD_CYCLES    (4),
    .CNT_W              (2),
    .TIMEOUT_CYCLES     (32)
  ) dut (
    .GL0          (GL0),
    .RESET_N      (RESET_N),
    .LOCK         (LOCK),
    .CLR_STATUS   (CLR_STATUS),
    .SYS_RESET_N  (SYS_RESET_N),
    .READY        (READY),
    .LOCK_LOST    (LOCK_LOST),
    .LOSS_COUNT   (LOSS_COUNT),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  );

  // Advance one rising edge and settle; inputs change only between edges.
  task automatic tick();
    @(posedge GL0);
    #1;
  endtask

  task automatic apply_reset();
    RESET_N    = 1'b0;
    LOCK       = 1'b0;
    CLR_STATUS = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT, LOCK_TIMEOUT} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT, LOCK_TIMEOUT});
    end
    $display("test_reset: outputs=%b", {SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT, LOCK_TIMEOUT});
  endtask

  task automatic test_acquire();
    apply_reset();
    LOCK = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if ({SYS_RESET_N, READY} !== 2'b00) begin
        errors++;
        $display("FAIL acquire_hold edge %0d: got %b expected 00", e, {SYS_RESET_N, READY});
      end
    end
    tick();
    checks++;
    if ({SYS_RESET_N, READY, LOCK_LOST} !== 3'b110) begin
      errors++;
      $display("FAIL acquire_release edge 15: got %b expected 110", {SYS_RESET_N, READY, LOCK_LOST});
    end
    $display("test_acquire: release edge 15 rst_n=%b ready=%b", SYS_RESET_N, READY);
  endtask

  task automatic test_glitch_restart();
    apply_reset();
    LOCK = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    LOCK = 1'b0;
    tick();
    LOCK = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if ({SYS_RESET_N, READY} !== 2'b00) begin
        errors++;
        $display("FAIL glitch_hold edge %0d: got %b expected 00", e, {SYS_RESET_N, READY});
      end
    end
    tick();
    checks++;
    if ({SYS_RESET_N, READY} !== 2'b11) begin
      errors++;
      $display("FAIL glitch_release edge 15: got %b expected 11", {SYS_RESET_N, READY});
    end
    $display("test_glitch_restart: rst_n=%b ready=%b", SYS_RESET_N, READY);
  endtask

  // Runs from S_RUN with LOSS_COUNT=0.
  task automatic test_run_loss();
    LOCK = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      tick();
      checks++;
      if ({SYS_RESET_N, READY, LOCK_LOST} !== 3'b110) begin
        errors++;
        $display("FAIL loss_latency edge %0d: got %b expected 110", e, {SYS_RESET_N, READY, LOCK_LOST});
      end
    end
    tick();
    checks++;
    if ({SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT} !== 5'b00101) begin
      errors++;
      $display("FAIL loss_assert edge 3: got %b expected 00101",
               {SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT});
    end
    LOCK = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if (SYS_RESET_N !== 1'b0) begin
        errors++;
        $display("FAIL relock_hold edge %0d: got %b expected 0", e, SYS_RESET_N);
      end
    end
    tick();
    checks++;
    if ({SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT} !== 5'b11101) begin
      errors++;
      $display("FAIL relock_release: got %b expected 11101", {SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT});
    end
    $display("test_run_loss: lost=%b count=%0d", LOCK_LOST, LOSS_COUNT);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    CLR_STATUS = 1'b1;
    tick();
    CLR_STATUS = 1'b0;
    checks++;
    if ({SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT} !== 5'b11000) begin
      errors++;
      $display("FAIL clr_status: got %b expected 11000", {SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT});
    end
    for (int n = 1; n <= 4; n++) begin
      exp_cnt = (n >= 3) ? 2'd3 : 2'(n);
      LOCK = 1'b0;
      for (int e = 1; e <= 3; e++) tick();
      checks++;
      if ({LOCK_LOST, LOSS_COUNT} !== {1'b1, exp_cnt}) begin
        errors++;
        $display("FAIL loss_count event %0d: got %b expected %b", n, {LOCK_LOST, LOSS_COUNT}, {1'b1, exp_cnt});
      end
      LOCK = 1'b1;
      for (int e = 1; e <= 15; e++) tick();
      checks++;
      if (READY !== 1'b1) begin
        errors++;
        $display("FAIL sat_relock event %0d: got %b expected 1", n, READY);
      end
      $display("test_saturation: event %0d count=%0d", n, LOSS_COUNT);
    end
    LOCK = 1'b0;
    tick();
    tick();
    CLR_STATUS = 1'b1;
    tick();
    CLR_STATUS = 1'b0;
    checks++;
    if ({SYS_RESET_N, LOCK_LOST, LOSS_COUNT} !== 4'b0101) begin
      errors++;
      $display("FAIL clr_vs_loss: got %b expected 0101", {SYS_RESET_N, LOCK_LOST, LOSS_COUNT});
    end
    $display("test_saturation: clr+loss lost=%b count=%0d", LOCK_LOST, LOSS_COUNT);
  endtask

  task automatic test_timeout();
    logic exp_to;
    apply_reset();
    for (int e = 1; e <= 40; e++) begin
      tick();
`ifdef LOCK_TIMEOUT_EN
      exp_to = (e >= 32);
`else
      exp_to = 1'b0;
`endif
      checks++;
      if (LOCK_TIMEOUT !== exp_to) begin
        errors++;
        $display("FAIL timeout edge %0d: got %b expected %b", e, LOCK_TIMEOUT, exp_to);
      end
    end
    CLR_STATUS = 1'b1;
    tick();
    CLR_STATUS = 1'b0;
    checks++;
    if ({LOCK_TIMEOUT, SYS_RESET_N} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_clear: got %b expected 00", {LOCK_TIMEOUT, SYS_RESET_N});
    end
    $display("test_timeout: after clear timeout=%b", LOCK_TIMEOUT);
  endtask

  task automatic test_reset_in_hold();
    apply_reset();
    LOCK = 1'b1;
    for (int e = 1; e <= 12; e++) tick();
    RESET_N = 1'b0;
    tick();
    checks++;
    if ({SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT, LOCK_TIMEOUT} !== 6'b0) begin
      errors++;
      $display("FAIL hold_reset: got %b expected 000000",
               {SYS_RESET_N, READY, LOCK_LOST, LOSS_COUNT, LOCK_TIMEOUT});
    end
    RESET_N = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      checks++;
      if ({SYS_RESET_N, READY} !== 2'b00) begin
        errors++;
        $display("FAIL hold_requal edge %0d: got %b expected 00", e, {SYS_RESET_N, READY});
      end
    end
    tick();
    checks++;
    if ({SYS_RESET_N, READY} !== 2'b11) begin
      errors++;
      $display("FAIL hold_requal_release: got %b expected 11", {SYS_RESET_N, READY});
    end
    $display("test_reset_in_hold: rst_n=%b ready=%b", SYS_RESET_N, READY);
  endtask

  initial begin
    RESET_N    = 1'b0;
    LOCK       = 1'b0;
    CLR_STATUS = 1'b0;
    test_reset();
    test_acquire();
    test_glitch_restart();
    test_run_loss();
    test_saturation();
    test_timeout();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
